// File: rtl/xgmii_pkg.sv
// XGMII character set, lane geometry and deframer state encoding shared by the rx path.
// Latency: none (declarations and a pure combinational helper only).
// Backpressure: not applicable.
package xgmii_pkg;

    localparam int LANES = 8;

    localparam logic [7:0] CH_START = 8'hFB;
    localparam logic [7:0] CH_TERM  = 8'hFD;
    localparam logic [7:0] CH_IDLE  = 8'h07;
    localparam logic [7:0] CH_ERROR = 8'hFE;
    localparam logic [7:0] CH_PRE   = 8'h55;
    localparam logic [7:0] CH_SFD   = 8'hD5;

    typedef enum logic [2:0] {
        IDLE,
        PRE4,
        ALIGNED,
        SHIFTED,
        FLUSH
    } rx_state_e;

    // Zero every byte lane at or above nbytes so partial beats carry no stale bytes.
    function automatic logic [63:0] keep_low_bytes(input logic [63:0] dat, input logic [3:0] nbytes);
        logic [63:0] res;
        res = '0;
        for (int i = 0; i < LANES; i++) begin
            if (4'(i) < nbytes) begin
                res[8*i +: 8] = dat[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/xgmii_ctrl_detect.sv
// Priority encoder: lowest lane carrying a control character, and whether it is /T/.
// Latency: purely combinational.
// Backpressure: not applicable.
module xgmii_ctrl_detect
    import xgmii_pkg::*;
(
    input  logic [63:0] data,
    input  logic [7:0]  ctrl,
    output logic        found,
    output logic [2:0]  lane,
    output logic        is_term
);

    // Scan from the top lane down so the lowest control lane is the one left standing.
    always_comb begin
        found   = 1'b0;
        lane    = 3'd0;
        is_term = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (ctrl[i]) begin
                found   = 1'b1;
                lane    = 3'(i);
                is_term = (data[8*i +: 8] == CH_TERM);
            end
        end
    end

endmodule

// File: rtl/xgmii_rx_deframer.sv
// XGMII 64-bit receive deframer: finds /S/ on lane 0 or 4, checks preamble/SFD, emits byte-aligned beats.
// Latency: beat valid 2 cycles after its last byte arrives; a lane-4 residual (flush) beat takes 3.
// Backpressure: none; XGMII cannot stall, so beats are pushed out unconditionally.
module xgmii_rx_deframer
    import xgmii_pkg::*;
#(
    parameter int MAX_BYTES = 9600
) (
    input  logic        mgt_clk,
    input  logic        reset_n,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    output logic [63:0] rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic [3:0]  rx_nbytes,
    output logic        rx_err,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam logic [14:0] MAX_LIM = 15'(MAX_BYTES);

    rx_state_e   state_q, state_d;
    logic [63:0] w_dat_q, w_dat_d;
    logic [7:0]  w_ctl_q, w_ctl_d;
    logic [31:0] hold_q, hold_d;
    logic [13:0] cnt_q, cnt_d;
    logic        sof_pend_q, sof_pend_d;
    logic [3:0]  flush_n_q, flush_n_d;
    logic        flush_err_q, flush_err_d;

    logic [63:0] rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_sof_q, rx_sof_d;
    logic        rx_eof_q, rx_eof_d;
    logic [3:0]  rx_nbytes_q, rx_nbytes_d;
    logic        rx_err_q, rx_err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic        w_found, w_term, x_found, x_term;
    logic [2:0]  w_lane, x_lane;
    logic        start_lane0, start_lane4, sfd_lane3;

    logic        beat_go, beat_eof, beat_cerr;
    logic [3:0]  beat_n;
    logic [63:0] beat_dat;
    logic [14:0] cnt_sum;
    logic        over_max;

    // Frame end search on the staged word W.
    xgmii_ctrl_detect u_det_w (
        .data    (w_dat_q),
        .ctrl    (w_ctl_q),
        .found   (w_found),
        .lane    (w_lane),
        .is_term (w_term)
    );

    // One-word lookahead on the live input X, used to close aligned frames whose end falls on lane 0.
    xgmii_ctrl_detect u_det_x (
        .data    (xgmii_rxd),
        .ctrl    (xgmii_rxc),
        .found   (x_found),
        .lane    (x_lane),
        .is_term (x_term)
    );

    // Start-of-frame patterns on W: full lane-0 preamble, lane-4 start, and the SFD half-word that follows it.
    always_comb begin
        start_lane0 = (w_ctl_q == 8'h01) && (w_dat_q[7:0] == CH_START) &&
                      (w_dat_q[55:8] == {6{CH_PRE}}) && (w_dat_q[63:56] == CH_SFD);
        start_lane4 = (w_ctl_q[7:4] == 4'b0001) && (w_dat_q[39:32] == CH_START) &&
                      (w_dat_q[63:40] == {3{CH_PRE}});
        sfd_lane3   = (w_ctl_q[3:0] == 4'b0000) && (w_dat_q[23:0] == {3{CH_PRE}}) &&
                      (w_dat_q[31:24] == CH_SFD);
    end

    // Next-state, beat selection, byte counting and statistics.
    always_comb begin
        state_d     = state_q;
        w_dat_d     = xgmii_rxd;
        w_ctl_d     = xgmii_rxc;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        sof_pend_d  = sof_pend_q;
        flush_n_d   = flush_n_q;
        flush_err_d = flush_err_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;

        rx_data_d   = '0;
        rx_valid_d  = 1'b0;
        rx_sof_d    = 1'b0;
        rx_eof_d    = 1'b0;
        rx_nbytes_d = '0;
        rx_err_d    = 1'b0;

        beat_go   = 1'b0;
        beat_eof  = 1'b0;
        beat_cerr = 1'b0;
        beat_n    = 4'd8;
        beat_dat  = w_dat_q;
        cnt_sum   = '0;
        over_max  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_lane0) begin
                    state_d    = ALIGNED;
                    sof_pend_d = 1'b1;
                    cnt_d      = '0;
                end else if (start_lane4) begin
                    state_d = PRE4;
                end
            end
            PRE4: begin
                // Bad SFD after a lane-4 start: drop silently, nothing counted.
                if (sfd_lane3) begin
                    state_d    = SHIFTED;
                    hold_d     = w_dat_q[63:32];
                    sof_pend_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            ALIGNED: begin
                if (w_found) begin
                    if (w_lane == 3'd0) begin
                        // Only reachable on the word right after /S/: zero-length frame.
                        err_cnt_d = err_cnt_q + 16'd1;
                    end else begin
                        beat_go   = 1'b1;
                        beat_eof  = 1'b1;
                        beat_n    = {1'b0, w_lane};
                        beat_cerr = !w_term;
                    end
                    state_d = IDLE;
                end else begin
                    beat_go   = 1'b1;
                    beat_eof  = x_found && (x_lane == 3'd0);
                    beat_cerr = !x_term;
                    if (beat_eof) begin
                        state_d = IDLE;
                    end
                end
            end
            SHIFTED: begin
                beat_go  = 1'b1;
                beat_dat = {w_dat_q[31:0], hold_q};
                hold_d   = w_dat_q[63:32];
                if (w_found && (w_lane <= 3'd4)) begin
                    beat_eof  = 1'b1;
                    beat_n    = 4'd4 + {1'b0, w_lane};
                    beat_cerr = !w_term;
                    state_d   = IDLE;
                end else if (w_found) begin
                    flush_n_d   = {1'b0, w_lane} - 4'd4;
                    flush_err_d = !w_term;
                    state_d     = FLUSH;
                end
            end
            FLUSH: begin
                beat_go   = 1'b1;
                beat_eof  = 1'b1;
                beat_dat  = {32'd0, hold_q};
                beat_n    = flush_n_q;
                beat_cerr = flush_err_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (beat_go) begin
            cnt_sum     = {1'b0, cnt_q} + {11'd0, beat_n};
            cnt_d       = cnt_sum[14] ? 14'h3FFF : cnt_sum[13:0];
            over_max    = cnt_sum > MAX_LIM;
            rx_valid_d  = 1'b1;
            rx_data_d   = keep_low_bytes(beat_dat, beat_n);
            rx_nbytes_d = beat_n;
            rx_sof_d    = sof_pend_q;
            sof_pend_d  = 1'b0;
            rx_eof_d    = beat_eof;
            rx_err_d    = beat_eof && (beat_cerr || over_max);
            if (beat_eof) begin
                if (rx_err_d) begin
                    err_cnt_d = err_cnt_q + 16'd1;
                end else begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
        end
    end

    // State, staging and output registers; reset drops any partial frame.
    always_ff @(posedge mgt_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            w_dat_q     <= '0;
            w_ctl_q     <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            sof_pend_q  <= 1'b0;
            flush_n_q   <= '0;
            flush_err_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_sof_q    <= 1'b0;
            rx_eof_q    <= 1'b0;
            rx_nbytes_q <= '0;
            rx_err_q    <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            w_dat_q     <= w_dat_d;
            w_ctl_q     <= w_ctl_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            sof_pend_q  <= sof_pend_d;
            flush_n_q   <= flush_n_d;
            flush_err_q <= flush_err_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_sof_q    <= rx_sof_d;
            rx_eof_q    <= rx_eof_d;
            rx_nbytes_q <= rx_nbytes_d;
            rx_err_q    <= rx_err_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_sof    = rx_sof_q;
    assign rx_eof    = rx_eof_q;
    assign rx_nbytes = rx_nbytes_q;
    assign rx_err    = rx_err_q;
    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_xgmii_rx_deframer.sv
// Bench for the XGMII rx deframer: frames are described as byte lanes, expected beats derived from payloads.
// Latency: expected beat cycle = word holding its last byte + 2 (+1 for a lane-4 residual).
// Backpressure: none to model; every expected beat must appear on its cycle.
module tb_xgmii_rx_deframer;
    import xgmii_pkg::*;

    localparam int TB_MAX = 64;

    logic        mgt_clk = 1'b0;
    logic        reset_n;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic [63:0] rx_data;
    logic        rx_valid, rx_sof, rx_eof, rx_err;
    logic [3:0]  rx_nbytes;
    logic [15:0] frame_cnt, err_cnt;

    xgmii_rx_deframer #(.MAX_BYTES(TB_MAX)) dut (
        .mgt_clk   (mgt_clk),
        .reset_n   (reset_n),
        .xgmii_rxd (xgmii_rxd),
        .xgmii_rxc (xgmii_rxc),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_sof    (rx_sof),
        .rx_eof    (rx_eof),
        .rx_nbytes (rx_nbytes),
        .rx_err    (rx_err),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 mgt_clk = ~mgt_clk;

    typedef struct {
        logic [7:0] b;
        logic       c;
    } lane_t;

    typedef struct {
        logic [63:0] dat;
        logic [3:0]  n;
        logic        sof;
        logic        eof;
        logic        err;
        int          cyc;
    } beat_t;

    lane_t lq[$];
    beat_t exp_q[$];
    int    zl_q[$];

    int checks = 0;
    int errors = 0;
    int m_fc = 0;
    int m_ec = 0;
    int beats_seen = 0;
    int cur_idx = 0;
    bit run = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push(input logic [7:0] b, input logic c);
        lane_t l;
        l.b = b;
        l.c = c;
        lq.push_back(l);
    endfunction

    function automatic logic [63:0] low_bytes(input logic [63:0] d, input logic [3:0] n);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < int'(n)) r[8*k +: 8] = d[8*k +: 8];
        end
        return r;
    endfunction

    // Append one frame to the lane stream and record what the deframer must produce for it.
    task automatic add_frame(input int start_lane, input int len, input logic [7:0] term,
                             input bit bad_sfd, input logic [7:0] seed);
        int    pos[$];
        int    term_pos, nb, last;
        beat_t bt;
        while (lq.size() % 8 != 0) push(CH_IDLE, 1'b1);
        for (int i = 0; i < 8 + start_lane; i++) push(CH_IDLE, 1'b1);
        push(CH_START, 1'b1);
        for (int i = 0; i < 6; i++) push(CH_PRE, 1'b0);
        push(bad_sfd ? CH_PRE : CH_SFD, 1'b0);
        for (int i = 0; i < len; i++) begin
            pos.push_back(lq.size());
            push(seed + 8'(i), 1'b0);
        end
        term_pos = lq.size();
        push(term, 1'b1);
        while (lq.size() % 8 != 0) push(CH_IDLE, 1'b1);
        for (int i = 0; i < 16; i++) push(CH_IDLE, 1'b1);
        if (bad_sfd) return;
        if (len == 0) begin
            zl_q.push_back(term_pos / 8 + 2);
            return;
        end
        for (int j = 0; j * 8 < len; j++) begin
            nb     = (len - j * 8 > 8) ? 8 : len - j * 8;
            bt.dat = '0;
            for (int k = 0; k < nb; k++) bt.dat[8*k +: 8] = seed + 8'(j * 8 + k);
            bt.n   = 4'(nb);
            bt.sof = (j == 0);
            bt.eof = (j * 8 + nb == len);
            bt.err = bt.eof && ((term != CH_TERM) || (len > TB_MAX));
            last   = pos[j * 8 + nb - 1];
            bt.cyc = last / 8 + 2 + ((start_lane == 4 && last % 8 >= 4) ? 1 : 0);
            exp_q.push_back(bt);
        end
    endtask

    task automatic drive_word(input int w);
        for (int k = 0; k < 8; k++) begin
            xgmii_rxd[8*k +: 8] = lq[w * 8 + k].b;
            xgmii_rxc[k]        = lq[w * 8 + k].c;
        end
    endtask

    task automatic drive_idle();
        xgmii_rxd = {8{CH_IDLE}};
        xgmii_rxc = 8'hFF;
    endtask

    // Play the lane stream one word per cycle with the scoreboard enabled, then drain.
    task automatic run_stream();
        int nw;
        while (lq.size() % 8 != 0) push(CH_IDLE, 1'b1);
        for (int i = 0; i < 32; i++) push(CH_IDLE, 1'b1);
        nw = lq.size() / 8;
        for (int w = 0; w < nw; w++) begin
            @(posedge mgt_clk);
            #1;
            drive_word(w);
            cur_idx = w;
            run     = 1'b1;
        end
        @(negedge mgt_clk);
        #1;
        run = 1'b0;
        chk("leftover_beats", 64'(exp_q.size()), 64'd0);
        chk("leftover_zero_len", 64'(zl_q.size()), 64'd0);
        lq.delete();
    endtask

    // Scoreboard: every sampled cycle checks beats, idle zeros and both counters.
    always @(negedge mgt_clk) begin
        beat_t e;
        if (run) begin
            while (zl_q.size() > 0 && zl_q[0] <= cur_idx) begin
                m_ec++;
                void'(zl_q.pop_front());
            end
            if (rx_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(rx_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    beats_seen++;
                    chk("beat_cycle", 64'(cur_idx), 64'(e.cyc));
                    chk("beat_data", low_bytes(rx_data, e.n), e.dat);
                    chk("beat_nbytes", 64'(rx_nbytes), 64'(e.n));
                    chk("beat_sof", 64'(rx_sof), 64'(e.sof));
                    chk("beat_eof", 64'(rx_eof), 64'(e.eof));
                    chk("beat_err", 64'(rx_err), 64'(e.err));
                    if (e.eof) begin
                        if (e.err) m_ec++;
                        else       m_fc++;
                    end
                end
            end else begin
                chk("idle_data", rx_data, 64'd0);
                chk("idle_nbytes", 64'(rx_nbytes), 64'd0);
                chk("idle_err", 64'(rx_err), 64'd0);
                if (exp_q.size() > 0 && exp_q[0].cyc < cur_idx) begin
                    chk("missing_beat", 64'(rx_valid), 64'd1);
                    void'(exp_q.pop_front());
                end
            end
            chk("frame_cnt", 64'(frame_cnt), 64'(m_fc));
            chk("err_cnt", 64'(err_cnt), 64'(m_ec));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        drive_idle();
        #12;
        chk("rst_valid", 64'(rx_valid), 64'd0);
        chk("rst_data", rx_data, 64'd0);
        chk("rst_sof", 64'(rx_sof), 64'd0);
        chk("rst_eof", 64'(rx_eof), 64'd0);
        chk("rst_nbytes", 64'(rx_nbytes), 64'd0);
        chk("rst_err", 64'(rx_err), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        @(negedge mgt_clk);
        reset_n = 1'b1;

        add_frame(0, 64, CH_TERM,  1'b0, 8'h00); // 8 beats, exactly at the size limit
        add_frame(4, 61, CH_TERM,  1'b0, 8'h10); // lane-4 start, /T/ lane 1, eof nbytes 5
        add_frame(4, 59, CH_TERM,  1'b0, 8'h20); // lane-4 start, /T/ lane 7, flush of 3 bytes
        add_frame(0, 19, CH_ERROR, 1'b0, 8'h30); // /E/ lane 3 of 3rd data word
        add_frame(4, 40, CH_TERM,  1'b1, 8'h40); // bad SFD: dropped silently
        add_frame(0, 16, CH_ERROR, 1'b0, 8'h50); // /E/ on lane 0 of next word via lookahead
        add_frame(0, 72, CH_TERM,  1'b0, 8'h60); // over the size limit, 9 beats
        add_frame(4, 65, CH_TERM,  1'b0, 8'h70); // /T/ lane 5: flush 1 byte, over limit
        add_frame(0, 0,  CH_TERM,  1'b0, 8'h00); // zero-length
        add_frame(0, 5,  CH_TERM,  1'b0, 8'hA0); // single beat: sof and eof together
        run_stream();
        chk("p1_frame_cnt", 64'(frame_cnt), 64'd4);
        chk("p1_err_cnt", 64'(err_cnt), 64'd5);
        chk("p1_beats", 64'(beats_seen), 64'd48);

        // Reset in the middle of a frame: outputs and counters clear at once.
        add_frame(0, 64, CH_TERM, 1'b0, 8'h80);
        exp_q.delete();
        for (int w = 0; w < 5; w++) begin
            @(posedge mgt_clk);
            #1;
            drive_word(w);
        end
        @(negedge mgt_clk);
        chk("mid_valid", 64'(rx_valid), 64'd1);
        chk("mid_sof", 64'(rx_sof), 64'd1);
        chk("mid_data", rx_data, 64'h8786858483828180);
        #1;
        reset_n = 1'b0;
        drive_idle();
        #1;
        chk("arst_valid", 64'(rx_valid), 64'd0);
        chk("arst_data", rx_data, 64'd0);
        chk("arst_sof", 64'(rx_sof), 64'd0);
        chk("arst_nbytes", 64'(rx_nbytes), 64'd0);
        chk("arst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("arst_err_cnt", 64'(err_cnt), 64'd0);
        @(posedge mgt_clk);
        #3;
        reset_n = 1'b1;
        lq.delete();
        exp_q.delete();
        zl_q.delete();
        m_fc = 0;
        m_ec = 0;

        add_frame(0, 64, CH_TERM, 1'b0, 8'h90);
        add_frame(4, 61, CH_TERM, 1'b0, 8'hC0);
        run_stream();
        chk("p2_frame_cnt", 64'(frame_cnt), 64'd2);
        chk("p2_err_cnt", 64'(err_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
